muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add / restoring-divide core with
// single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             muldiv_start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             muldiv_resp,
    output logic [WIDTH-1:0] muldiv_out
);
    localparam int CW = $clog2(ITER);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic [2:0]         op, op_nxt;
    logic [WIDTH-1:0]   opb, opb_nxt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic               neg_q, neg_q_nxt;
    logic               neg_r, neg_r_nxt;
    logic               handoff, handoff_nxt;
    logic [WIDTH-1:0]   out_nxt;

    // Input decode for the IDLE sampling cycle
    logic             sign_a, sign_b, div_zero, div_ovf;
    logic [WIDTH-1:0] mag_a, mag_b, fast_res;

    always_comb begin
        sign_a   = rs1_data[WIDTH-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                                        funct3 == 3'b100 || funct3 == 3'b110);
        sign_b   = rs2_data[WIDTH-1] & (funct3 == 3'b001 || funct3 == 3'b100 ||
                                        funct3 == 3'b110);
        mag_a    = sign_a ? -rs1_data : rs1_data;
        mag_b    = sign_b ? -rs2_data : rs2_data;
        div_zero = funct3[2] && (rs2_data == '0);
        div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) &&
                   (rs1_data == MIN_NEG) && (rs2_data == '1);
        if (div_zero)
            fast_res = funct3[1] ? rs1_data : '1;
        else
            fast_res = funct3[1] ? '0 : MIN_NEG;
    end

    // One iteration of either core; acc holds {hi, multiplier} or {rem, quot}
    logic [WIDTH:0]     mul_sum, rem_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, step, prod_fix;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH-1:0]   result;

    always_comb begin
        mul_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb})
                          : {1'b0, acc[2*WIDTH-1:WIDTH]};
        mul_step = {mul_sum, acc[WIDTH-1:1]};
        div_sh   = {acc, 1'b0};
        rem_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opb};
        div_step = rem_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                                   : {rem_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
        step     = op[2] ? div_step : mul_step;
        prod_fix = neg_q ? -step : step;
        case (op)
            3'b000:                 result = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         result = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
            default:                result = neg_r ? -step[2*WIDTH-1:WIDTH]
                                                   : step[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        op_nxt      = op;
        opb_nxt     = opb;
        acc_nxt     = acc;
        neg_q_nxt   = neg_q;
        neg_r_nxt   = neg_r;
        out_nxt     = muldiv_out;
        handoff_nxt = 1'b0;
        case (state)
            IDLE: begin
                // First IDLE cycle after DONE is the handoff: ID/EX is only now
                // presenting the next instruction, so start is not sampled yet.
                if (muldiv_start && !handoff) begin
                    op_nxt    = funct3;
                    neg_q_nxt = sign_a ^ sign_b;
                    neg_r_nxt = sign_a;
                    count_nxt = '0;
                    if (funct3[2]) begin
                        opb_nxt = mag_b;
                        acc_nxt = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opb_nxt = mag_a;
                        acc_nxt = {{WIDTH{1'b0}}, mag_b};
                    end
                    if (div_zero || div_ovf) begin
                        out_nxt   = fast_res;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!muldiv_start) begin
                    state_nxt = IDLE;
                end else begin
                    acc_nxt   = step;
                    count_nxt = count + CW'(1);
                    if (count == CW'(ITER - 1)) begin
                        out_nxt   = result;
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                handoff_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            op         <= '0;
            opb        <= '0;
            acc        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            handoff    <= 1'b0;
            muldiv_out <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            op         <= op_nxt;
            opb        <= opb_nxt;
            acc        <= acc_nxt;
            neg_q      <= neg_q_nxt;
            neg_r      <= neg_r_nxt;
            handoff    <= handoff_nxt;
            muldiv_out <= out_nxt;
        end
    end

    assign muldiv_resp = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        muldiv_start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        muldiv_resp;
    logic [31:0] muldiv_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_out;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .muldiv_start(muldiv_start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .muldiv_resp(muldiv_resp), .muldiv_out(muldiv_out)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib; return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = ia % ib; return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drives one op with start held until resp, scrambling operands while busy.
    // Returns the cycle of the first resp seen (-1 if none), the result, and
    // whether resp was still high the cycle after. Leaves the bench two cycles
    // past resp so the next start lands on a sampling IDLE cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic late_resp);
        funct3 = f;
        rs1_data = a;
        rs2_data = b;
        muldiv_start = 1'b1;
        lat = -1;
        res = 32'hx;
        if (muldiv_resp) lat = 0;
        for (int c = 1; c <= 50 && lat < 0; c++) begin
            @(posedge clk); #1;
            rs1_data = $urandom;
            rs2_data = $urandom;
            if (muldiv_resp) begin
                lat = c;
                res = muldiv_out;
            end
        end
        muldiv_start = 1'b0;
        @(posedge clk); #1;
        late_resp = muldiv_resp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        muldiv_start = 1'b0;
        funct3 = 3'd0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (muldiv_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b expected 0", muldiv_resp); end
        n_checks++;
        if (muldiv_out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 00000000", muldiv_out); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (muldiv_resp !== 1'b0 || muldiv_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_release: resp %b out %h expected 0 00000000", muldiv_resp, muldiv_out);
        end
    endtask

    task automatic test_multiply();
        logic [2:0]  tf[4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] ta[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] te[4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat;
        logic late;
        for (int i = 0; i < 4; i++) begin
            run_op(tf[i], ta[i], tb[i], res, lat, late);
            n_checks++;
            if (res !== te[i]) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", i, res, te[i]); end
            n_checks++;
            if (lat != 33) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
            n_checks++;
            if (late !== 1'b0) begin n_fail++; $display("FAIL mul_resp_width[%0d]: resp high in cycle 34", i); end
            last_out = te[i];
        end
    endtask

    task automatic test_divide();
        logic [2:0]  tf[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] tb[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] te[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int lat;
        logic late;
        for (int i = 0; i < 4; i++) begin
            run_op(tf[i], ta[i], tb[i], res, lat, late);
            n_checks++;
            if (res !== te[i]) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, te[i]); end
            n_checks++;
            if (lat != 33) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
            last_out = te[i];
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  tf[4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] ta[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        int lat;
        logic late;
        for (int i = 0; i < 4; i++) begin
            run_op(tf[i], ta[i], tb[i], res, lat, late);
            n_checks++;
            if (res !== te[i]) begin n_fail++; $display("FAIL fast_result[%0d]: got %h expected %h", i, res, te[i]); end
            n_checks++;
            if (lat != 1) begin n_fail++; $display("FAIL fast_latency[%0d]: got %0d expected 1", i, lat); end
            n_checks++;
            if (late !== 1'b0) begin n_fail++; $display("FAIL fast_resp_width[%0d]: resp high in cycle 2", i); end
            last_out = te[i];
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, exp, res;
        int lat, elat;
        logic late;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            exp  = ref_model(f, a, b);
            elat = ref_latency(f, a, b);
            run_op(f, a, b, res, lat, late);
            n_checks++;
            if (res !== exp) begin
                n_fail++; $display("FAIL rand_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp);
            end
            n_checks++;
            if (lat != elat) begin n_fail++; $display("FAIL rand_latency[%0d] f=%0d: got %0d expected %0d", i, f, lat, elat); end
            last_out = exp;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        int cyc[$];
        logic [31:0] outs[$];
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        funct3 = 3'd0;
        rs1_data = a1;
        rs2_data = b1;
        muldiv_start = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            @(posedge clk); #1;
            if (muldiv_resp) begin
                cyc.push_back(c);
                outs.push_back(muldiv_out);
            end
            if (c == 34) begin rs1_data = a2; rs2_data = b2; end
            if (c == 36) begin rs1_data = $urandom; rs2_data = $urandom; end
            if (c == 69) muldiv_start = 1'b0;
        end
        n_checks++;
        if (cyc.size() != 2) begin
            n_fail++; $display("FAIL b2b_resp_count: got %0d expected 2", cyc.size());
        end else begin
            n_checks++;
            if (cyc[0] != 33 || cyc[1] != 68) begin
                n_fail++; $display("FAIL b2b_resp_cycles: got %0d,%0d expected 33,68", cyc[0], cyc[1]);
            end
            n_checks++;
            if (outs[0] !== ref_model(3'd0, a1, b1)) begin
                n_fail++; $display("FAIL b2b_first: got %h expected %h", outs[0], ref_model(3'd0, a1, b1));
            end
            n_checks++;
            if (outs[1] !== ref_model(3'd0, a2, b2)) begin
                n_fail++; $display("FAIL b2b_second: got %h expected %h", outs[1], ref_model(3'd0, a2, b2));
            end
        end
        last_out = ref_model(3'd0, a2, b2);
    endtask

    task automatic test_flush();
        logic [31:0] a, b, res, exp;
        int lat, nresp;
        logic late;
        a = 32'($urandom_range(1000, 100000));
        b = 32'($urandom_range(3, 99));
        funct3 = 3'd4;
        rs1_data = a;
        rs2_data = b;
        muldiv_start = 1'b1;
        nresp = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (muldiv_resp) nresp++;
            if (c == 10) muldiv_start = 1'b0;
        end
        n_checks++;
        if (nresp != 0) begin n_fail++; $display("FAIL flush_resp: got %0d resp pulses expected 0", nresp); end
        n_checks++;
        if (muldiv_out !== last_out) begin n_fail++; $display("FAIL flush_out_hold: got %h expected %h", muldiv_out, last_out); end
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        exp = ref_model(3'd6, a, b);
        run_op(3'd6, a, b, res, lat, late);
        n_checks++;
        if (res !== exp || lat != 33) begin
            n_fail++; $display("FAIL flush_next_op: got %h at cycle %0d expected %h at cycle 33", res, lat, exp);
        end
        last_out = exp;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res, exp, a, b;
        int lat, nresp;
        logic late;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, late);
        n_checks++;
        if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL rstmid_setup: got %h expected ffffffeb", res); end
        funct3 = 3'd0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        muldiv_start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (muldiv_resp !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp: got %b expected 0", muldiv_resp); end
        n_checks++;
        if (muldiv_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_out: got %h expected 00000000", muldiv_out); end
        muldiv_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nresp = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (muldiv_resp) nresp++;
        end
        n_checks++;
        if (nresp != 0) begin n_fail++; $display("FAIL rstmid_no_resp: got %0d resp pulses expected 0", nresp); end
        a = $urandom;
        b = $urandom;
        exp = ref_model(3'd1, a, b);
        run_op(3'd1, a, b, res, lat, late);
        n_checks++;
        if (res !== exp || lat != 33) begin
            n_fail++; $display("FAIL rstmid_next_op: got %h at cycle %0d expected %h at cycle 33", res, lat, exp);
        end
    endtask

    initial begin
        last_out = 32'h0;
        test_reset();
        test_multiply();
        test_divide();
        test_fast_path();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
